// File: rtl/blk_move.sv
// rtl/blk_move.sv - frame-rate block mover with synchronised buttons and play-field clamping
//
// Ports:
//   clk         pixel clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   frame_tick  one-clk pulse per frame; the only cycle in which the position updates
//   btn_up/btn_down/btn_left/btn_right  raw asynchronous push-buttons, active-high
//   blkpos_x    block top-left x (11 bits)
//   blkpos_y    block top-left y (10 bits)
//   blk_moving  high while the last frame update changed the position
//
// Build option: BLK_MOVE_ACCEL_EN adds a speed register (1..MAX_STEP) that replaces STEP.

module blk_move #(
    parameter int STEP     = 4,
    parameter int MAX_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [10:0] blkpos_x,
    output logic [9:0]  blkpos_y,
    output logic        blk_moving
);

    // Limits keep the 32x32 block fully inside the play field.
    localparam logic signed [11:0] X_MIN = 12'sd10;
    localparam logic signed [11:0] X_MAX = 12'sd1397;
    localparam logic signed [11:0] Y_MIN = 12'sd10;
    localparam logic signed [11:0] Y_MAX = 12'sd857;
    localparam logic [10:0]        X_RST = 11'd704;
    localparam logic [9:0]         Y_RST = 10'd434;

    // Button bit order: {up, down, left, right}
    logic [3:0] btn_meta;
    logic [3:0] btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta <= 4'b0000;
            btn_sync <= 4'b0000;
        end else begin
            btn_meta <= {btn_up, btn_down, btn_left, btn_right};
            btn_sync <= btn_meta;
        end
    end

    // Opposing buttons cancel on their axis.
    logic mv_up, mv_down, mv_left, mv_right, mv_any;
    assign mv_up    = btn_sync[3] & ~btn_sync[2];
    assign mv_down  = btn_sync[2] & ~btn_sync[3];
    assign mv_left  = btn_sync[1] & ~btn_sync[0];
    assign mv_right = btn_sync[0] & ~btn_sync[1];
    assign mv_any   = mv_up | mv_down | mv_left | mv_right;

    logic signed [11:0] step;

`ifdef BLK_MOVE_ACCEL_EN
    localparam int SPD_W = $clog2(MAX_STEP + 1);
    logic [SPD_W-1:0] speed;

    // Speed keeps climbing while a direction is held, even against a limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed <= SPD_W'(1);
        end else if (frame_tick) begin
            if (!mv_any)
                speed <= SPD_W'(1);
            else if (speed != SPD_W'(MAX_STEP))
                speed <= speed + SPD_W'(1);
        end
    end

    assign step = 12'(speed);
`else
    assign step = 12'(STEP);

    if (MAX_STEP < 1) begin : g_max_step_chk
    end

    logic unused_any;
    assign unused_any = mv_any;
`endif

    // 12-bit signed intermediates so x-step / y-step cannot underflow before clamping.
    logic signed [11:0] x_cur, y_cur, x_sum, y_sum, x_clip, y_clip;
    logic [10:0]        x_new;
    logic [9:0]         y_new;
    logic               changed;

    always_comb begin
        x_cur = $signed({1'b0, blkpos_x});
        y_cur = $signed({2'b00, blkpos_y});

        x_sum = x_cur;
        if (mv_left)
            x_sum = x_cur - step;
        else if (mv_right)
            x_sum = x_cur + step;

        y_sum = y_cur;
        if (mv_up)
            y_sum = y_cur - step;
        else if (mv_down)
            y_sum = y_cur + step;

        x_clip = x_sum;
        if (x_sum < X_MIN)
            x_clip = X_MIN;
        else if (x_sum > X_MAX)
            x_clip = X_MAX;

        y_clip = y_sum;
        if (y_sum < Y_MIN)
            y_clip = Y_MIN;
        else if (y_sum > Y_MAX)
            y_clip = Y_MAX;

        x_new   = x_clip[10:0];
        y_new   = y_clip[9:0];
        changed = (x_new != blkpos_x) || (y_new != blkpos_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blkpos_x   <= X_RST;
            blkpos_y   <= Y_RST;
            blk_moving <= 1'b0;
        end else if (frame_tick) begin
            blkpos_x   <= x_new;
            blkpos_y   <= y_new;
            blk_moving <= changed;
        end
    end

    logic unused_clip;
    assign unused_clip = x_clip[11] ^ y_clip[11] ^ y_clip[10];

endmodule

// File: tb/tb_blk_move.sv
// tb/tb_blk_move.sv - directed self-checking bench for blk_move

module tb_blk_move;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [10:0] blkpos_x;
    logic [9:0]  blkpos_y;
    logic        blk_moving;

    int n_vec = 0;
    int n_err = 0;

    blk_move #(.STEP(4), .MAX_STEP(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .blkpos_x   (blkpos_x),
        .blkpos_y   (blkpos_y),
        .blk_moving (blk_moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        repeat (3) @(posedge clk);
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int mv);
        chk({tag, "_x"}, int'(blkpos_x), x);
        chk({tag, "_y"}, int'(blkpos_y), y);
        chk({tag, "_mv"}, int'(blk_moving), mv);
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_pos("reset", 704, 434, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        ticks(3);
        #1;
        chk_pos("idle3", 704, 434, 0);

`ifdef BLK_MOVE_ACCEL_EN
        begin
            int y_exp;
            int inc;
            y_exp = 434;
            set_btn(0, 1, 0, 0);
            for (int i = 1; i <= 10; i++) begin
                inc = (i > 8) ? 8 : i;
                y_exp += inc;
                tick();
                chk("accel_y", int'(blkpos_y), y_exp);
                repeat (2) @(posedge clk);
            end
            chk_pos("accel_end", 704, 486, 1);
            set_btn(0, 0, 0, 0);
            tick();
            chk_pos("accel_rel", 704, 486, 0);
            set_btn(0, 1, 0, 0);
            tick();
            chk_pos("accel_restart", 704, 487, 1);
            set_btn(0, 0, 0, 0);
        end
`else
        // Right twice: check the value is still old just before the tick edge.
        set_btn(0, 0, 0, 1);
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        chk("right1_pre", int'(blkpos_x), 704);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        chk_pos("right1", 708, 434, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("right1_hold", int'(blkpos_x), 708);
        tick();
        chk_pos("right2", 712, 434, 1);

        // Opposing vertical buttons cancel; diagonal right still applies.
        set_btn(1, 1, 0, 1);
        tick();
        chk_pos("updown_right", 716, 434, 1);

        // Left to the x minimum: 716 - 176*4 = 12, then clamp at 10.
        set_btn(0, 0, 1, 0);
        ticks(176);
        chk_pos("left_12", 12, 434, 1);
        tick();
        chk_pos("left_clamp", 10, 434, 1);
        tick();
        chk_pos("left_stuck", 10, 434, 0);

        // Up exactly onto y minimum: 434 - 106*4 = 10.
        set_btn(1, 0, 0, 0);
        ticks(106);
        chk_pos("up_min", 10, 10, 1);
        tick();
        chk_pos("up_stuck", 10, 10, 0);

        // Down: 10 + 211*4 = 854, next step saturates to 857.
        set_btn(0, 1, 0, 0);
        ticks(211);
        chk_pos("down_854", 10, 854, 1);
        tick();
        chk_pos("down_clamp", 10, 857, 1);
        tick();
        chk_pos("down_stuck", 10, 857, 0);

        // Right: 10 + 346*4 = 1394, next step saturates to 1397.
        set_btn(0, 0, 0, 1);
        ticks(346);
        chk_pos("right_1394", 1394, 857, 1);
        tick();
        chk_pos("right_clamp", 1397, 857, 1);
        set_btn(0, 0, 0, 0);

        // Press one cycle before the tick: still inside the synchroniser, ignored.
        @(negedge clk);
        btn_left = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        btn_left = 1'b0;
        chk_pos("late_edge", 1397, 857, 0);
        repeat (4) @(posedge clk);
        tick();
        chk_pos("no_queue", 1397, 857, 0);

        // Asynchronous reset mid-frame while moving.
        set_btn(0, 0, 1, 0);
        tick();
        chk_pos("pre_rst", 1393, 857, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_pos("async_rst", 704, 434, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_pos("post_rst_hold", 704, 434, 0);
        tick();
        chk_pos("post_rst_tick", 700, 434, 1);
        set_btn(0, 0, 0, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blk_move.md
BLK_MOVE -- requirements
Module: blk_move

Interface
REQ-001 The module SHALL have parameter STEP, default 4, giving the fixed move distance in pixels per frame.
REQ-002 The module SHALL have parameter MAX_STEP, default 8, giving the speed ceiling in pixels per frame when acceleration is compiled in.
REQ-003 The module SHALL have port clk, input, 1 bit: the pixel clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port frame_tick, input, 1 bit: a one-clk pulse once per frame from the timing generator.
REQ-006 The module SHALL have ports btn_up, btn_down, btn_left and btn_right, input, 1 bit each: raw, asynchronous push-buttons, active-high.
REQ-007 The module SHALL have port blkpos_x, output, 11 bits: block top-left x, fed to the draw stage.
REQ-008 The module SHALL have port blkpos_y, output, 10 bits: block top-left y, fed to the draw stage.
REQ-009 The module SHALL have port blk_moving, output, 1 bit: high while the last frame update changed the position.

Function
REQ-010 Each btn_* SHALL pass through a 2-flop synchroniser before use; raw inputs never reach the datapath.
REQ-011 Position SHALL update only on a clk edge where frame_tick=1, using the synchronised buttons sampled in that cycle; new values are visible one clk after that edge.
REQ-012 Between frame_ticks, blkpos_x, blkpos_y and blk_moving SHALL hold their values.
REQ-013 For each axis, only one button of the pair SHALL move the block; both pressed or neither pressed means no motion on that axis.
REQ-014 Up SHALL decrease y, down SHALL increase y, left SHALL decrease x and right SHALL increase x, each by the current step; diagonal motion is allowed.
REQ-015 Arithmetic SHALL use 12-bit signed intermediates so the subtract cannot underflow before clamping.
REQ-016 Clamp limits SHALL keep the 32x32 block fully inside the play field: X_MIN=10, X_MAX=1397, Y_MIN=10, Y_MAX=857.
REQ-017 A result below the minimum SHALL saturate to the minimum, and a result above the maximum SHALL saturate to the maximum; there is no wrap-around.
REQ-018 A clamped move SHALL stop exactly at the limit; any later push into the limit SHALL leave the position unchanged.
REQ-019 At each frame_tick, blk_moving SHALL be set to 1 if either coordinate changes and to 0 otherwise, including when a push into a limit produces no change.
REQ-020 Button edges inside the synchroniser pipeline when frame_tick arrives SHALL be ignored until the next frame_tick; there is no queueing.

Reset
REQ-021 While rst_n=0, blkpos_x SHALL be 704, blkpos_y SHALL be 434, blk_moving SHALL be 0, the synchronisers SHALL be cleared and speed SHALL be 1.
REQ-022 Reset asserted mid-frame or mid-move SHALL take effect immediately with no partial update.
REQ-023 After rst_n deasserts, the first frame_tick SHALL see synchronised buttons no earlier than 2 clk later.

Configuration
REQ-024 Macro BLK_MOVE_ACCEL_EN SHALL control acceleration; when it is undefined, the step is always STEP and the speed register is not built.
REQ-025 When BLK_MOVE_ACCEL_EN is defined, an internal speed register (range 1..MAX_STEP) SHALL replace STEP as the step.
REQ-026 With acceleration on, a frame_tick with any direction pressed SHALL move by the current speed and then increment speed, saturating at MAX_STEP.
REQ-027 With acceleration on, a frame_tick with no effective direction SHALL reset speed to 1.
REQ-028 With acceleration on, speed SHALL still increment when a move is fully clamped, as long as a button is held.

Verification
REQ-029 Reset release, no buttons, 3 frame_ticks -> position SHALL stay (704,434) and blk_moving SHALL be 0.
REQ-030 btn_right held for 2 frame_ticks, accel off -> x SHALL read 708 then 712, with each update appearing 1 clk after its tick and blk_moving=1.
REQ-031 Start at x=12, btn_left held, 1 tick, accel off -> x SHALL be 10; a further tick -> x SHALL stay 10 and blk_moving SHALL be 0.
REQ-032 btn_up and btn_down held together with btn_right, 1 tick -> y SHALL be unchanged and x SHALL be +4.
REQ-033 With BLK_MOVE_ACCEL_EN, btn_down held for 10 ticks -> y increments SHALL be 1,2,...,8,8,8; after release and 1 tick, then press -> the next increment SHALL be 1.
REQ-034 rst_n pulsed low mid-frame while moving -> outputs SHALL be (704,434,0) asynchronously, with no update until the next frame_tick.
